imem_fetch_ctrl: RTL

- Fetch sequencer in front of the synchronous-read instruction memory; owns the fetch PC.
- Issues one word-aligned read per cycle, absorbs the 1-cycle memory latency in a small instruction queue, and presents instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects (flushing stale fetches) and a halt request.

---
 rtl/imem_fetch_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// imem_fetch_ctrl : fetch PC owner; one imem read per cycle, 1-cycle read
//                   latency absorbed in a small queue, valid/ready to decode.
// Revision        : 1.0
// ============================================================================
module imem_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    QDEPTH     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_imem_req,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_rdata,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  input  logic                  i_halt,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_inst_pc,
  output logic                  o_halted
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]        DEPTH_LIM  = (CNT_W+1)'(QDEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [INST_WIDTH-1:0] qmem_inst [QDEPTH];
  logic [ADDR_WIDTH-1:0] qmem_pc   [QDEPTH];

  logic                  redir_act;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [CNT_W:0]        occ;

  always_comb begin
    redir_act    = i_redirect_valid && (state_q != ST_BOOT);
    redir_pc     = i_redirect_pc & ALIGN_MASK;
    empty        = (count_q == '0);
    o_inst_valid = !empty && !i_redirect_valid;
    pop          = o_inst_valid && i_inst_ready;
    // a redirect flushes the queue, so the returning response is dropped
    push         = inflight_q && !redir_act;
    // slots committed once this cycle's push/pop retire
    occ          = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

    state_d    = state_q;
    pc_d       = pc_q;
    issue      = 1'b0;
    fetch_addr = pc_q;

    case (state_q)
      ST_BOOT: begin
        state_d = i_halt ? ST_HALT : ST_FETCH;
        if (i_redirect_valid) pc_d = redir_pc;
      end
      ST_FETCH: begin
        state_d = i_halt ? ST_HALT : ST_FETCH;
        if (redir_act) begin
          fetch_addr = redir_pc;
          issue      = !i_halt;
        end else begin
          issue = (occ < DEPTH_LIM) && !i_halt;
        end
      end
      ST_HALT: begin
        if (redir_act) begin
          state_d    = ST_FETCH;
          fetch_addr = redir_pc;
          issue      = !i_halt;
        end else if (!i_halt) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (issue)          pc_d = fetch_addr + PC_STEP;
    else if (redir_act) pc_d = redir_pc;

    inflight_d    = issue;
    inflight_pc_d = fetch_addr;

    if (redir_act) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC & ALIGN_MASK;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // payload storage needs no reset: count gates every read
  always_ff @(posedge i_clk) begin
    if (push) begin
      qmem_inst[wr_ptr_q] <= i_imem_rdata;
      qmem_pc[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign o_imem_req  = issue;
  assign o_imem_addr = fetch_addr;
  assign o_inst      = empty ? '0 : qmem_inst[rd_ptr_q];
  assign o_inst_pc   = empty ? '0 : qmem_pc[rd_ptr_q];
  assign o_halted    = (state_q == ST_HALT) && empty && !inflight_q;

endmodule
`default_nettype wire
